// File: rtl/bsk_mgr_common_param_pkg.sv
// Shared defaults, derived widths and FSM state type for the BSK manager cut sequencer.
package bsk_mgr_common_param_pkg;

   localparam int BSK_CUT_NB = 4;
   localparam int CUT_DEPTH  = 16;
   localparam int SLOT_NB    = 8;
   localparam int ITER_W     = 4;

   function automatic int clog2_min1(input int value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

   localparam int CUT_ID_W = clog2_min1(BSK_CUT_NB);
   localparam int ADD_W    = clog2_min1(SLOT_NB * CUT_DEPTH);
   localparam int SLOT_W   = clog2_min1(SLOT_NB);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/bsk_mgr_cut_next_find.sv
// Combinational cut scanner: next enabled cut above the current one, wrap flag
// (no enabled cut above) and the lowest enabled cut.
module bsk_mgr_cut_next_find #(
   parameter int BSK_CUT_NB = 4,
   parameter int CUT_ID_W   = 2
) (
   input  logic [BSK_CUT_NB-1:0] mask_i,
   input  logic [CUT_ID_W-1:0]   cur_cut_i,
   output logic [CUT_ID_W-1:0]   next_cut_o,
   output logic                  wrap_o,
   output logic [CUT_ID_W-1:0]   first_cut_o
);

   // Descending scan so the last hit is the lowest qualifying index.
   always_comb begin
      next_cut_o  = '0;
      wrap_o      = 1'b1;
      first_cut_o = '0;
      for (int i = BSK_CUT_NB - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            first_cut_o = CUT_ID_W'(i);
            if (i > int'(cur_cut_i)) begin
               next_cut_o = CUT_ID_W'(i);
               wrap_o     = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/bsk_mgr_cut_rd_seq.sv
// BSK cut read-address sequencer: sweeps iteration/word/enabled-cut per command.
// Optional per-command cut mask enabled by defining BSK_MGR_CUT_MASK_EN.
module bsk_mgr_cut_rd_seq #(
   parameter int BSK_CUT_NB = bsk_mgr_common_param_pkg::BSK_CUT_NB,
   parameter int CUT_DEPTH  = bsk_mgr_common_param_pkg::CUT_DEPTH,
   parameter int SLOT_NB    = bsk_mgr_common_param_pkg::SLOT_NB,
   parameter int ITER_W     = bsk_mgr_common_param_pkg::ITER_W,
   localparam int CUT_ID_W  = (BSK_CUT_NB > 1) ? $clog2(BSK_CUT_NB) : 1,
   localparam int ADD_W     = (SLOT_NB * CUT_DEPTH > 1) ? $clog2(SLOT_NB * CUT_DEPTH) : 1,
   localparam int SLOT_W    = (SLOT_NB > 1) ? $clog2(SLOT_NB) : 1
) (
   input  logic                  clk,
   input  logic                  s_rst_n,
   input  logic                  cmd_vld,
   output logic                  cmd_rdy,
   input  logic [SLOT_W-1:0]     cmd_slot,
   input  logic [ITER_W-1:0]     cmd_iter,
`ifdef BSK_MGR_CUT_MASK_EN
   input  logic [BSK_CUT_NB-1:0] cmd_cut_mask,
`endif
   output logic                  rd_vld,
   input  logic                  rd_rdy,
   output logic [CUT_ID_W-1:0]   rd_cut_id,
   output logic [ADD_W-1:0]      rd_add,
   output logic                  rd_last,
   output logic                  done,
   output logic                  busy
);

   import bsk_mgr_common_param_pkg::*;

   localparam int                WORD_W    = (CUT_DEPTH > 1) ? $clog2(CUT_DEPTH) : 1;
   localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(CUT_DEPTH - 1);

   seq_state_e            state_q, state_d;
   logic [BSK_CUT_NB-1:0] cmd_mask, mask_sel, mask_q, mask_d;
   logic [ADD_W-1:0]      cmd_base, base_q, base_d, add_q, add_d;
   logic [ITER_W-1:0]     iter_last_q, iter_last_d, iter_cnt_q, iter_cnt_d;
   logic [WORD_W-1:0]     word_q, word_d;
   logic [CUT_ID_W-1:0]   cut_q, cut_d, nxt_cut, first_cut, hi_cut;
   logic                  nxt_wrap;
   logic                  vld_q, vld_d, last_q, last_d;
   logic                  done_q, done_d, busy_q, busy_d, rdy_q, rdy_d;

`ifdef BSK_MGR_CUT_MASK_EN
   assign cmd_mask = cmd_cut_mask;
`else
   assign cmd_mask = '1;
`endif

   // In IDLE the scanner looks at the incoming command so the first cut is ready at accept.
   assign mask_sel = (state_q == IDLE) ? cmd_mask : mask_q;
   assign cmd_base = ADD_W'(32'(cmd_slot) * 32'(CUT_DEPTH));

   bsk_mgr_cut_next_find #(
      .BSK_CUT_NB (BSK_CUT_NB),
      .CUT_ID_W   (CUT_ID_W)
   ) u_next_find (
      .mask_i      (mask_sel),
      .cur_cut_i   (cut_q),
      .next_cut_o  (nxt_cut),
      .wrap_o      (nxt_wrap),
      .first_cut_o (first_cut)
   );

   always_comb begin
      hi_cut = '0;
      for (int i = 0; i < BSK_CUT_NB; i++) begin
         if (mask_sel[i]) hi_cut = CUT_ID_W'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      base_d      = base_q;
      iter_last_d = iter_last_q;
      iter_cnt_d  = iter_cnt_q;
      word_d      = word_q;
      cut_d       = cut_q;
      add_d       = add_q;
      case (state_q)
         IDLE: begin
            if (cmd_vld && rdy_q) begin
               mask_d      = cmd_mask;
               base_d      = cmd_base;
               iter_last_d = (cmd_iter == '0) ? '0 : cmd_iter - 1'b1;
               iter_cnt_d  = '0;
               word_d      = '0;
               cut_d       = first_cut;
               add_d       = cmd_base;
               state_d     = (cmd_mask == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (rd_rdy) begin
               if (last_q) begin
                  state_d = DONE;
               end else if (!nxt_wrap) begin
                  cut_d = nxt_cut;
               end else begin
                  cut_d = first_cut;
                  if (word_q == WORD_LAST) begin
                     word_d     = '0;
                     iter_cnt_d = iter_cnt_q + 1'b1;
                     add_d      = base_q;
                  end else begin
                     word_d = word_q + 1'b1;
                     add_d  = add_q + 1'b1;
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      last_d = (state_d == RUN) && (iter_cnt_d == iter_last_d) &&
               (word_d == WORD_LAST) && (cut_d == hi_cut);
      vld_d  = (state_d == RUN);
      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
      rdy_d  = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         base_q      <= '0;
         iter_last_q <= '0;
         iter_cnt_q  <= '0;
         word_q      <= '0;
         cut_q       <= '0;
         add_q       <= '0;
         last_q      <= 1'b0;
         vld_q       <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         base_q      <= base_d;
         iter_last_q <= iter_last_d;
         iter_cnt_q  <= iter_cnt_d;
         word_q      <= word_d;
         cut_q       <= cut_d;
         add_q       <= add_d;
         last_q      <= last_d;
         vld_q       <= vld_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         rdy_q       <= rdy_d;
      end
   end

   assign cmd_rdy   = rdy_q;
   assign rd_vld    = vld_q;
   assign rd_cut_id = cut_q;
   assign rd_add    = add_q;
   assign rd_last   = last_q;
   assign done      = done_q;
   assign busy      = busy_q;

`ifndef SYNTHESIS
   slot_range_a : assert property (@(posedge clk) disable iff (!s_rst_n)
      (cmd_vld && cmd_rdy) |-> (32'(cmd_slot) < 32'(SLOT_NB)));
`endif

endmodule
